// File: rtl/addressdecode_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// addressdecode_cycle_ctrl_pkg
// Shared dock definitions: cycle FSM state encoding, slot count, the packed
// output bundle of the cycle controller and a one-cold chip-select helper.
// Reused by the cycle controller, the window decoder and configuration blocks.
// ---------------------------------------------------------------------------
package addressdecode_cycle_ctrl_pkg;

   localparam int unsigned NUM_SLOTS = 8;
   localparam int unsigned SLOT_W    = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERR    = 2'd3
   } cyc_state_e;

   typedef struct packed {
      logic [NUM_SLOTS-1:0] slot_cs_n;
      logic                 buf_oe_n;
      logic                 buf_dir;
      logic                 host_rdy_n;
      logic                 bus_err;
   } cyc_outs_t;

   localparam cyc_outs_t IDLE_OUTS = '{
      slot_cs_n:  8'hFF,
      buf_oe_n:   1'b1,
      buf_dir:    1'b0,
      host_rdy_n: 1'b1,
      bus_err:    1'b0
   };

   // One-cold chip-select vector for a slot index.
   function automatic logic [NUM_SLOTS-1:0] slot_onecold(input logic [SLOT_W-1:0] slot);
      logic [NUM_SLOTS-1:0] v;
      v       = {NUM_SLOTS{1'b1}};
      v[slot] = 1'b0;
      return v;
   endfunction

endpackage : addressdecode_cycle_ctrl_pkg

// File: rtl/addressdecode_cycle_ctrl_timeout.sv
// ---------------------------------------------------------------------------
// cycle_timeout_cnt
// Counts ACTIVE cycles of a bus cycle. expire_o is high while the counter
// sits at TIMEOUT_CYC-1, i.e. during the last permitted ACTIVE cycle.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset (counter -> 0)
//   clr_i     synchronous clear, has priority over en_i
//   en_i      advance the counter by one
//   expire_o  counter has reached TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
module cycle_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expire_o = (cnt_q == LAST_CNT);

   // Next count: clear wins, and the counter never runs past the last value.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : cycle_timeout_cnt

// File: rtl/addressdecode_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// addressdecode_cycle_ctrl
// Host I/O cycle controller for the dock slots. A host request that hits a
// decoder window selects one slot, enables the data buffer and waits for the
// slot's ready; unmapped requests and slots that never answer end in a bus
// error. Every output comes straight from a register.
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   iorq_n_i       host I/O request, active low (synchronous to clk_i)
//   is_read_i      1 = read, 0 = write (from the window decoder)
//   win_valid_i    decoder window hit
//   sel_slot_i     decoded target slot
//   slot_rdy_n_i   per-slot ready, active low
//   slot_cs_n_o    per-slot chip select, active low, one-cold or all high
//   buf_oe_n_o     data buffer enable, active low
//   buf_dir_o      1 = slot-to-host, 0 = host-to-slot
//   host_rdy_n_o   cycle complete to host, active low
//   bus_err_o      current cycle ended in error
//   err_cnt_o      saturating count of errored cycles
// ---------------------------------------------------------------------------
module addressdecode_cycle_ctrl
   import addressdecode_cycle_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 iorq_n_i,
   input  logic                 is_read_i,
   input  logic                 win_valid_i,
   input  logic [SLOT_W-1:0]    sel_slot_i,
   input  logic [NUM_SLOTS-1:0] slot_rdy_n_i,
   output logic [NUM_SLOTS-1:0] slot_cs_n_o,
   output logic                 buf_oe_n_o,
   output logic                 buf_dir_o,
   output logic                 host_rdy_n_o,
   output logic                 bus_err_o,
   output logic [7:0]           err_cnt_o
);

   cyc_state_e          state_q, state_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic                rd_q, rd_d;
   logic                armed_q;
   logic [7:0]          err_cnt_q, err_cnt_d;
   cyc_outs_t           outs_q, outs_d;
   logic                cnt_clr_s;
   logic                cnt_en_s;
   logic                expire_s;

   cycle_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) u_timeout (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (cnt_clr_s),
      .en_i     (cnt_en_s),
      .expire_o (expire_s)
   );

   // Next state and slot/direction latch. armed_q holds off the very first
   // edge after reset so a cycle can only start on the second edge.
   // In ACTIVE a host abort beats ready, and ready beats the timeout.
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      rd_d      = rd_q;
      cnt_clr_s = 1'b0;
      cnt_en_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!iorq_n_i && armed_q) begin
               if (win_valid_i) begin
                  state_d   = ST_ACTIVE;
                  slot_d    = sel_slot_i;
                  rd_d      = is_read_i;
                  cnt_clr_s = 1'b1;
               end else begin
                  state_d = ST_ERR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (iorq_n_i) begin
               state_d = ST_IDLE;
            end else if (!slot_rdy_n_i[slot_q]) begin
               state_d = ST_DONE;
            end else if (expire_s) begin
               state_d = ST_ERR;
            end else begin
               state_d  = ST_ACTIVE;
               cnt_en_s = 1'b1;
            end
         end
         ST_DONE, ST_ERR: begin
            if (iorq_n_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values for the upcoming state, so the registered outputs line up
   // with the state register on the same edge.
   always_comb begin
      outs_d = IDLE_OUTS;
      case (state_d)
         ST_IDLE: begin
            outs_d = IDLE_OUTS;
         end
         ST_ACTIVE: begin
            outs_d.slot_cs_n = slot_onecold(slot_d);
            outs_d.buf_oe_n  = 1'b0;
            outs_d.buf_dir   = rd_d;
         end
         ST_DONE: begin
            outs_d.slot_cs_n  = slot_onecold(slot_d);
            outs_d.buf_oe_n   = 1'b0;
            outs_d.buf_dir    = rd_d;
            outs_d.host_rdy_n = 1'b0;
         end
         ST_ERR: begin
            outs_d.host_rdy_n = 1'b0;
            outs_d.bus_err    = 1'b1;
         end
         default: begin
            outs_d = IDLE_OUTS;
         end
      endcase
   end

   // Error counter: one step per entry into ERR, stuck at 255.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_d == ST_ERR) && (state_q != ST_ERR) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State, latched cycle attributes, error count and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         slot_q    <= '0;
         rd_q      <= 1'b0;
         armed_q   <= 1'b0;
         err_cnt_q <= 8'h00;
         outs_q    <= IDLE_OUTS;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         rd_q      <= rd_d;
         armed_q   <= 1'b1;
         err_cnt_q <= err_cnt_d;
         outs_q    <= outs_d;
      end
   end

   assign slot_cs_n_o  = outs_q.slot_cs_n;
   assign buf_oe_n_o   = outs_q.buf_oe_n;
   assign buf_dir_o    = outs_q.buf_dir;
   assign host_rdy_n_o = outs_q.host_rdy_n;
   assign bus_err_o    = outs_q.bus_err;
   assign err_cnt_o    = err_cnt_q;

endmodule : addressdecode_cycle_ctrl
